id_stage: RTL
=============

Name: id_stage

Overview:
- MIPS instruction-decode stage, directly downstream of instruction fetch.
- Consumes fetched instruction `Ins` and `nextPC` (PC+4).
- Contains the 32x32 register file, written from write-back.
- Decodes fields and control signals, extends immediates, and computes branch and jump targets.
- Detects load-use hazards and registers everything into the ID/EX pipeline boundary.

Parameters:
- RF_DEPTH, 32, number of architectural registers. Register 0 is hardwired to zero.
- XLEN, 32, datapath width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- Ins  in  32  instruction from fetch.
- nextPC  in  32  PC+4 of `Ins`.
- Ins_Valid  in  1  `Ins`/`nextPC` are meaningful.
- Stall  in  1  downstream hold; freeze all ID/EX outputs.
- Flush  in  1  branch/jump taken; kill the instruction being decoded.
- WB_WE  in  1  register-file write enable.
- WB_Addr  in  5  write-back destination.
- WB_Data  in  32  write-back data.
- Stall_req  out  1  load-use hazard; fetch must hold PC and `Ins`. Combinational.
- Valid_out  out  1  ID/EX slot holds a real instruction.
- Rs_Data, Rt_Data  out  32  register-file read data.
- Imm_Ext  out  32  extended immediate.
- Rs, Rt, W_Dst  out  5  source and destination register numbers.
- Funct  out  6  R-type funct field.
- Shamt  out  5  shift amount.
- RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump  out  1 each  control signals.
- BrTarget, JTarget, PC_out  out  32  branch target, jump target, nextPC pass-through.

Behaviour:
- Reset (asynchronous, RST=1): all outputs 0, `Valid_out`=0, all register-file entries 0.
- Latency: `Ins` present at edge n appears decoded on the outputs after edge n+1.
- Register file: written on posedge when `WB_WE`=1 and `WB_Addr`≠0. A write to register 0 is ignored and register 0 always reads 0. Read is combinational from `Ins`[25:21] and `Ins`[20:16].
- Field extraction: `Rs`=`Ins`[25:21], `Rt`=`Ins`[20:16], `Shamt`=`Ins`[10:6], `Funct`=`Ins`[5:0].
- Destination `W_Dst`:
  - R-type (opcode 0x00): `Ins`[15:11].
  - JAL (0x03): 31.
  - Otherwise: `Ins`[20:16].
- Immediate extension:
  - ANDI/ORI (0x0C/0x0D): zero-extend.
  - LUI (0x0F): {imm,16'h0}.
  - Otherwise: sign-extend.
- Targets:
  - `BrTarget` = `nextPC` + (sext(imm)<<2), modulo 2^32 (wraps silently).
  - `JTarget` = {`nextPC`[31:28], `Ins`[25:0], 2'b00}.
- Control decode:
  - LW (0x23): `MemRead`, `MemToReg`, `ALUSrc`, `RegWrite`.
  - SW (0x2B): `MemWrite`, `ALUSrc`.
  - BEQ/BNE (0x04/0x05): `Branch`.
  - J (0x02): `Jump`.
  - JAL (0x03): `Jump`, `RegWrite`.
  - ADDI/ADDIU/SLTI/ANDI/ORI/LUI: `ALUSrc`, `RegWrite`.
  - R-type: `RegWrite`.
  - Unknown opcode: all control 0, `Valid_out` still follows `Ins_Valid` (treated as NOP).
- Hazard: `Stall_req` = `Valid_out` & `MemRead` & `Ins_Valid` & (`W_Dst`≠0) & (`W_Dst`==`Rs`(Ins) | (`W_Dst`==`Rt`(Ins) & Ins uses rt)).
  - "Uses rt" means R-type, SW, BEQ or BNE.
- Update priority each posedge, highest first:
  1. RST.
  2. `Flush`: bubble — `Valid_out`=0, all control signals 0, data fields don't-care but driven 0.
  3. `Stall`: hold every output.
  4. `Stall_req`: insert bubble; fetch re-presents the same `Ins` next cycle.
  5. Normal: capture decode, `Valid_out`=`Ins_Valid`.
- A write-back write occurs even during `Stall`/`Flush`; the register file is never frozen.
- `Flush` and `Stall` together: `Flush` wins.
- RST mid-operation clears the pipeline slot immediately (asynchronously); no partial state survives.

Optional Feature:
- Macro: `ID_RF_BYPASS_EN`.
- Defined: a same-cycle write-back to a register being read returns `WB_Data` (write-first). `WB_Addr`=0 is never bypassed.
- Undefined: read returns the old contents. Write-back must then complete a cycle earlier, i.e. the pipeline tolerates a 3-instruction RAW gap.

Decomposition:
- Package `mips_pkg`:
  - Opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW.
  - REG_ZERO=0, REG_RA=31.
  - A packed control-bundle typedef.
- One sub-module: `reg_file` (2 read ports, 1 write port, asynchronous reset, optional bypass).

Test Plan:
- Reset: RST pulse mid-cycle → all outputs 0 immediately; after release, R1..R31 read 0.
- Decode: `Ins`=0x2008FFFF (ADDI $8,$0,-1), `nextPC`=0x104 → next cycle `Imm_Ext`=0xFFFFFFFF, `W_Dst`=8, `ALUSrc`=`RegWrite`=1, `Valid_out`=1, `BrTarget`=0x100.
- Register file:
  - `WB_WE`=1, `WB_Addr`=5, `WB_Data`=0xDEADBEEF, same cycle `Ins` reads $5 → `Rs_Data`=0xDEADBEEF with `ID_RF_BYPASS_EN`, 0 without.
  - Write to $0 → reads 0.
- Load-use: LW $9,0($8) followed by ADD $10,$9,$11 → `Stall_req`=1 for exactly one cycle, one bubble (`Valid_out`=0), then ADD decoded with `Rs`=9.
- Priority: assert `Flush` and `Stall` together on a valid ADDI → `Valid_out`=0 next cycle; `Stall` alone → outputs unchanged for every stalled cycle.
- JAL 0x0C000010 at `nextPC`=0x40000008 → `JTarget`=0x40000040, `W_Dst`=31, `Jump`=`RegWrite`=1.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg -- opcode constants, control bundle and decode helpers (rev 1.0)
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic alu_src;
      logic branch;
      logic jump;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: c.reg_write = 1'b1;
         OP_LW: begin
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.alu_src    = 1'b1;
            c.reg_write  = 1'b1;
         end
         OP_SW: begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
         end
         OP_BEQ, OP_BNE: c.branch = 1'b1;
         OP_J:           c.jump   = 1'b1;
         OP_JAL: begin
            c.jump      = 1'b1;
            c.reg_write = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Instructions whose rt field is a source operand rather than a destination.
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file -- 2R/1W register file, r0 hardwired to zero, optional write-first
// bypass under ID_RF_BYPASS_EN (rev 1.0)
// ---------------------------------------------------------------------------
module reg_file import mips_pkg::*; #(
   parameter int RF_DEPTH = 32,
   parameter int XLEN     = 32,
   localparam int AW      = $clog2(RF_DEPTH)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [AW-1:0]   raddr_a_i,
   input  logic [AW-1:0]   raddr_b_i,
   output logic [XLEN-1:0] rdata_a_o,
   output logic [XLEN-1:0] rdata_b_o
);

   logic [XLEN-1:0] mem_q [RF_DEPTH];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < RF_DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i && (waddr_i != AW'(REG_ZERO))) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   function automatic logic [XLEN-1:0] rd(input logic [AW-1:0] a);
      if (a == AW'(REG_ZERO)) return '0;
`ifdef ID_RF_BYPASS_EN
      if (we_i && (a == waddr_i)) return wdata_i;
`endif
      return mem_q[a];
   endfunction

   always_comb begin
      rdata_a_o = rd(raddr_a_i);
      rdata_b_o = rd(raddr_b_i);
   end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// id_stage -- MIPS decode stage with register file, load-use detection and
// ID/EX register; ID_RF_BYPASS_EN enables write-first RF reads (rev 1.0)
// ---------------------------------------------------------------------------
module id_stage import mips_pkg::*; #(
   parameter int RF_DEPTH = 32,
   parameter int XLEN     = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [31:0]     Ins,
   input  logic [XLEN-1:0] nextPC,
   input  logic            Ins_Valid,
   input  logic            Stall,
   input  logic            Flush,
   input  logic            WB_WE,
   input  logic [4:0]      WB_Addr,
   input  logic [XLEN-1:0] WB_Data,
   output logic            Stall_req,
   output logic            Valid_out,
   output logic [XLEN-1:0] Rs_Data,
   output logic [XLEN-1:0] Rt_Data,
   output logic [XLEN-1:0] Imm_Ext,
   output logic [4:0]      Rs,
   output logic [4:0]      Rt,
   output logic [4:0]      W_Dst,
   output logic [5:0]      Funct,
   output logic [4:0]      Shamt,
   output logic            RegWrite,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            MemToReg,
   output logic            ALUSrc,
   output logic            Branch,
   output logic            Jump,
   output logic [XLEN-1:0] BrTarget,
   output logic [XLEN-1:0] JTarget,
   output logic [XLEN-1:0] PC_out
);

   typedef struct packed {
      logic            valid;
      ctrl_t           ctrl;
      logic [XLEN-1:0] rs_data;
      logic [XLEN-1:0] rt_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      wdst;
      logic [5:0]      funct;
      logic [4:0]      shamt;
      logic [XLEN-1:0] br;
      logic [XLEN-1:0] jt;
      logic [XLEN-1:0] pc;
   } idex_t;

   idex_t           idex_q, idex_d, dec;
   logic [5:0]      opcode;
   logic [15:0]     imm16;
   logic [XLEN-1:0] sext;
   logic [XLEN-1:0] rs_rd, rt_rd;

   assign opcode = Ins[31:26];
   assign imm16  = Ins[15:0];
   assign sext   = {{(XLEN-16){imm16[15]}}, imm16};

   reg_file #(.RF_DEPTH(RF_DEPTH), .XLEN(XLEN)) u_rf (
      .CLK       (CLK),
      .RST       (RST),
      .we_i      (WB_WE),
      .waddr_i   (WB_Addr),
      .wdata_i   (WB_Data),
      .raddr_a_i (Ins[25:21]),
      .raddr_b_i (Ins[20:16]),
      .rdata_a_o (rs_rd),
      .rdata_b_o (rt_rd)
   );

   always_comb begin
      dec         = '0;
      dec.valid   = Ins_Valid;
      dec.ctrl    = Ins_Valid ? decode_ctrl(opcode) : '0;
      dec.rs_data = rs_rd;
      dec.rt_data = rt_rd;
      dec.rs      = Ins[25:21];
      dec.rt      = Ins[20:16];
      dec.funct   = Ins[5:0];
      dec.shamt   = Ins[10:6];
      case (opcode)
         OP_RTYPE: dec.wdst = Ins[15:11];
         OP_JAL:   dec.wdst = REG_RA;
         default:  dec.wdst = Ins[20:16];
      endcase
      case (opcode)
         OP_ANDI, OP_ORI: dec.imm = {{(XLEN-16){1'b0}}, imm16};
         OP_LUI:          dec.imm = {imm16, {(XLEN-16){1'b0}}};
         default:         dec.imm = sext;
      endcase
      dec.br = nextPC + (sext << 2);
      dec.jt = {nextPC[XLEN-1:28], Ins[25:0], 2'b00};
      dec.pc = nextPC;
   end

   // Load in ID/EX whose destination feeds the instruction now in decode.
   assign Stall_req = idex_q.valid & idex_q.ctrl.mem_read & Ins_Valid
                    & (idex_q.wdst != REG_ZERO)
                    & ((idex_q.wdst == Ins[25:21])
                       | ((idex_q.wdst == Ins[20:16]) & uses_rt(opcode)));

   always_comb begin
      idex_d = idex_q;
      if (Flush)          idex_d = '0;
      else if (Stall)     idex_d = idex_q;
      else if (Stall_req) idex_d = '0;
      else                idex_d = dec;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) idex_q <= '0;
      else     idex_q <= idex_d;
   end

   assign Valid_out = idex_q.valid;
   assign RegWrite  = idex_q.ctrl.reg_write;
   assign MemRead   = idex_q.ctrl.mem_read;
   assign MemWrite  = idex_q.ctrl.mem_write;
   assign MemToReg  = idex_q.ctrl.mem_to_reg;
   assign ALUSrc    = idex_q.ctrl.alu_src;
   assign Branch    = idex_q.ctrl.branch;
   assign Jump      = idex_q.ctrl.jump;
   assign Rs_Data   = idex_q.rs_data;
   assign Rt_Data   = idex_q.rt_data;
   assign Imm_Ext   = idex_q.imm;
   assign Rs        = idex_q.rs;
   assign Rt        = idex_q.rt;
   assign W_Dst     = idex_q.wdst;
   assign Funct     = idex_q.funct;
   assign Shamt     = idex_q.shamt;
   assign BrTarget  = idex_q.br;
   assign JTarget   = idex_q.jt;
   assign PC_out    = idex_q.pc;

endmodule
`default_nettype wire
